// File: rtl/ldpc_qc_pkg.sv
// ldpc_qc_pkg: code geometry and shift table shared by the QC-LDPC encoder and decoder.
//   QC_GF_LOG2 / QC_ROWN / QC_COLN : circulant log2 size, block rows, block columns
//   BLK_SIZE  : circulant size (2^QC_GF_LOG2 - 1); also the zero-block shift code
//   INFO_COLN : number of information block columns
//   COL_W, P_W, OCOL_W : info column, parity row and codeword column counter widths
//   SHIFT_TAB : packed shift table, entry (r,c) at bit ((r*QC_COLN + c) * QC_GF_LOG2)
package ldpc_qc_pkg;

   localparam int unsigned QC_GF_LOG2 = 7;
   localparam int unsigned QC_ROWN    = 6;
   localparam int unsigned QC_COLN    = 72;
   localparam int unsigned BLK_SIZE   = (1 << QC_GF_LOG2) - 1;
   localparam int unsigned INFO_COLN  = QC_COLN - QC_ROWN;
   // col counts up to INFO_COLN after the last info accept, so it needs one extra value
   localparam int unsigned COL_W      = $clog2(INFO_COLN + 1);
   localparam int unsigned P_W        = $clog2(QC_ROWN);
   localparam int unsigned OCOL_W     = $clog2(QC_COLN);
   localparam int unsigned TAB_W      = QC_ROWN * QC_COLN * QC_GF_LOG2;

   localparam logic [QC_GF_LOG2-1:0] ZERO_BLK = QC_GF_LOG2'(BLK_SIZE);

   typedef enum logic {ST_INFO, ST_PARITY} enc_state_e;

   // Info part: sparse pseudo-random shifts with some zero blocks.
   // Parity part: block diagonal, diagonal shift sp[r] = 19*r mod BLK_SIZE (never a zero block).
   function automatic logic [QC_GF_LOG2-1:0] gen_entry(int r, int c);
      int v;
      if (c >= int'(INFO_COLN)) begin
         if (c - int'(INFO_COLN) == r) v = (r * 19) % int'(BLK_SIZE);
         else                          v = int'(BLK_SIZE);
      end else if ((r * 7 + c * 3) % 11 == 0) begin
         v = int'(BLK_SIZE);
      end else begin
         v = (r * 37 + c * 53 + r * c * 11) % int'(BLK_SIZE);
      end
      return QC_GF_LOG2'(v);
   endfunction

   function automatic logic [TAB_W-1:0] gen_shift_tab();
      logic [TAB_W-1:0] tab;
      tab = '0;
      for (int r = 0; r < int'(QC_ROWN); r++) begin
         for (int c = 0; c < int'(QC_COLN); c++) begin
            tab[(r * int'(QC_COLN) + c) * int'(QC_GF_LOG2) +: QC_GF_LOG2] = gen_entry(r, c);
         end
      end
      return tab;
   endfunction

   localparam logic [TAB_W-1:0] SHIFT_TAB = gen_shift_tab();

   function automatic logic [QC_GF_LOG2-1:0] shift_at(int r, int c);
      return SHIFT_TAB[(r * int'(QC_COLN) + c) * int'(QC_GF_LOG2) +: QC_GF_LOG2];
   endfunction

endpackage

// File: rtl/qc_rotate.sv
// qc_rotate: combinational cyclic rotate of one circulant column.
//   x     : input column, 2^GF_SIZE_LOG2 - 1 bits
//   shift : rotate amount, 0 .. 2^GF_SIZE_LOG2 - 2
//   y     : y[k] = x[(k + shift) mod BLK]
module qc_rotate #(
   parameter int unsigned GF_SIZE_LOG2 = 7
) (
   input  logic [(1 << GF_SIZE_LOG2)-2:0] x,
   input  logic [GF_SIZE_LOG2-1:0]        shift,
   output logic [(1 << GF_SIZE_LOG2)-2:0] y
);

   localparam int unsigned BLK = (1 << GF_SIZE_LOG2) - 1;

   // {x,x} >> s exposes x[(k+s) mod BLK] at bit k for any s < BLK
   assign y = BLK'({x, x} >> shift);

endmodule

// File: rtl/ldpc_qc_encoder.sv
// ldpc_qc_encoder: systematic QC-LDPC encoder.
//   Accepts INFO_COLN information columns, emits them unchanged, then PCM_ROWN parity columns.
//   clk, rst (async, active high)
//   i_info / i_info_valid / o_info_ready          : information column input
//   o_codeword / o_codeword_valid / i_codeword_ready : codeword column output (single register)
//   o_codeword_last                                : marks the final parity column
//   o_check_err                                    : self-check failure pulse
// Optional feature macro ENC_SELF_CHECK_EN: re-computes every row syndrome of the emitted
// codeword and pulses o_check_err on the last handoff if any is nonzero. Undefined: tied 0.
module ldpc_qc_encoder
   import ldpc_qc_pkg::*;
#(
   parameter int unsigned GF_SIZE_LOG2 = QC_GF_LOG2,
   parameter int unsigned PCM_ROWN     = QC_ROWN,
   parameter int unsigned PCM_COLN     = QC_COLN
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [(1 << GF_SIZE_LOG2)-2:0] i_info,
   input  logic                          i_info_valid,
   output logic                          o_info_ready,
   output logic [(1 << GF_SIZE_LOG2)-2:0] o_codeword,
   output logic                          o_codeword_valid,
   input  logic                          i_codeword_ready,
   output logic                          o_codeword_last,
   output logic                          o_check_err
);

   localparam int unsigned BLK_N  = (1 << GF_SIZE_LOG2) - 1;
   localparam int unsigned INFO_N = PCM_COLN - PCM_ROWN;

   enc_state_e                             state_q, state_d;
   logic [COL_W-1:0]                       col_q, col_d;
   logic [P_W-1:0]                         p_q, p_d;
   logic [PCM_ROWN-1:0][BLK_N-1:0]         acc_q, acc_d;
   logic [BLK_N-1:0]                       out_q, out_d;
   logic                                   valid_q, valid_d;
   logic                                   last_q, last_d;

   logic [PCM_ROWN-1:0][GF_SIZE_LOG2-1:0]  sh_info;
   logic [PCM_ROWN-1:0][BLK_N-1:0]         rot_info;
   logic [BLK_N-1:0]                       acc_sel, par_col;
   logic [GF_SIZE_LOG2-1:0]                sp_sel, unrot_sh;
   logic                                   slot_free, accept, par_load, handoff;

   assign slot_free    = ~valid_q | i_codeword_ready;
   assign o_info_ready = ~rst & (state_q == ST_INFO) & slot_free;
   assign accept       = i_info_valid & o_info_ready;
   assign par_load     = (state_q == ST_PARITY) & slot_free;
   assign handoff      = valid_q & i_codeword_ready;

   for (genvar r = 0; r < PCM_ROWN; r++) begin : g_acc_rot
      assign sh_info[r] = shift_at(r, int'(col_q));
      qc_rotate #(
         .GF_SIZE_LOG2(GF_SIZE_LOG2)
      ) u_rot (
         .x    (i_info),
         .shift(sh_info[r]),
         .y    (rot_info[r])
      );
   end

   // Select acc[p] and its diagonal shift for the parity un-rotate
   always_comb begin
      acc_sel = '0;
      sp_sel  = '0;
      for (int r = 0; r < int'(PCM_ROWN); r++) begin
         if (p_q == P_W'(r)) begin
            acc_sel = acc_q[r];
            sp_sel  = shift_at(r, int'(INFO_N) + r);
         end
      end
      unrot_sh = (sp_sel == '0) ? '0 : GF_SIZE_LOG2'(BLK_N) - sp_sel;
   end

   qc_rotate #(
      .GF_SIZE_LOG2(GF_SIZE_LOG2)
   ) u_unrot (
      .x    (acc_sel),
      .shift(unrot_sh),
      .y    (par_col)
   );

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      p_d     = p_q;
      acc_d   = acc_q;
      out_d   = out_q;
      valid_d = valid_q;
      last_d  = last_q;

      if (handoff) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end

      if (accept) begin
         out_d   = i_info;
         valid_d = 1'b1;
         last_d  = 1'b0;
         for (int r = 0; r < int'(PCM_ROWN); r++) begin
            if (sh_info[r] != ZERO_BLK) acc_d[r] = acc_q[r] ^ rot_info[r];
         end
         col_d = col_q + COL_W'(1);
         if (col_q == COL_W'(INFO_N - 1)) begin
            state_d = ST_PARITY;
            p_d     = '0;
         end
      end else if (par_load) begin
         out_d   = par_col;
         valid_d = 1'b1;
         last_d  = (p_q == P_W'(PCM_ROWN - 1));
         p_d     = p_q + P_W'(1);
         if (p_q == P_W'(PCM_ROWN - 1)) begin
            acc_d   = '0;
            col_d   = '0;
            p_d     = '0;
            state_d = ST_INFO;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_INFO;
         col_q   <= '0;
         p_q     <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         p_q     <= p_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign o_codeword       = out_q;
   assign o_codeword_valid = valid_q;
   assign o_codeword_last  = last_q;

`ifdef ENC_SELF_CHECK_EN
   logic [OCOL_W-1:0]                      out_col_q, out_col_d;
   logic [PCM_ROWN-1:0][BLK_N-1:0]         chk_q, chk_d, rot_chk;
   logic [PCM_ROWN-1:0][GF_SIZE_LOG2-1:0]  sh_chk;
   logic                                   err_q, err_d;

   // Codeword column index of the word currently in the output register
   always_comb begin
      out_col_d = out_col_q;
      if (accept)        out_col_d = OCOL_W'(col_q);
      else if (par_load) out_col_d = OCOL_W'(INFO_N) + OCOL_W'(p_q);
   end

   for (genvar r = 0; r < PCM_ROWN; r++) begin : g_chk_rot
      assign sh_chk[r] = shift_at(r, int'(out_col_q));
      qc_rotate #(
         .GF_SIZE_LOG2(GF_SIZE_LOG2)
      ) u_rot_chk (
         .x    (out_q),
         .shift(sh_chk[r]),
         .y    (rot_chk[r])
      );
   end

   always_comb begin
      chk_d = chk_q;
      err_d = 1'b0;
      if (handoff) begin
         for (int r = 0; r < int'(PCM_ROWN); r++) begin
            if (sh_chk[r] != ZERO_BLK) chk_d[r] = chk_q[r] ^ rot_chk[r];
         end
         if (last_q) begin
            err_d = |chk_d;
            chk_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_col_q <= '0;
         chk_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         out_col_q <= out_col_d;
         chk_q     <= chk_d;
         err_q     <= err_d;
      end
   end

   assign o_check_err = err_q;
`else
   assign o_check_err = 1'b0;
`endif

endmodule

// File: tb/tb_ldpc_qc_encoder.sv
module tb_ldpc_qc_encoder;
   import ldpc_qc_pkg::*;

   localparam int B  = 127;
   localparam int NI = 66;
   localparam int NC = 72;
   localparam int NR = 6;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [B-1:0] i_info = '0;
   logic         i_info_valid = 1'b0;
   logic         o_info_ready;
   logic [B-1:0] o_codeword;
   logic         o_codeword_valid;
   logic         i_codeword_ready = 1'b1;
   logic         o_codeword_last;
   logic         o_check_err;

   ldpc_qc_encoder u_dut (
      .clk             (clk),
      .rst             (rst),
      .i_info          (i_info),
      .i_info_valid    (i_info_valid),
      .o_info_ready    (o_info_ready),
      .o_codeword      (o_codeword),
      .o_codeword_valid(o_codeword_valid),
      .i_codeword_ready(i_codeword_ready),
      .o_codeword_last (o_codeword_last),
      .o_check_err     (o_check_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard entries are {last, column}
   logic [B:0]   sb_q[$];
   logic [B-1:0] info_buf[NI];
   logic [B-1:0] frame_buf[NC];
   bit           sb_en = 1'b1;
   bit           err_allowed = 1'b0;
   int           rdy_mode = 0;
   int           hand_cnt = 0;
   int           first_cyc = -1;
   int           last_cyc = -1;
   int           first_acc_cyc = -1;
   int           err_pulses = 0;
   int           err_cyc = -1;
   int           beat = 0;
   bit           hold_pend = 1'b0;
   logic [B-1:0] hold_d;
   logic         hold_l;

   function automatic logic [B-1:0] ref_rot(input logic [B-1:0] x, input int s);
      logic [B-1:0] y;
      for (int k = 0; k < B; k++) y[k] = x[(k + s) % B];
      return y;
   endfunction

   function automatic logic [B-1:0] rand127();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[B-1:0];
   endfunction

   function automatic bit syndrome_ok();
      logic [B-1:0] a;
      int s;
      for (int r = 0; r < NR; r++) begin
         a = '0;
         for (int c = 0; c < NC; c++) begin
            s = int'(shift_at(r, c));
            if (s != B) a = a ^ ref_rot(frame_buf[c], s);
         end
         if (a != '0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Golden model: accumulate rotated info per row, un-rotate by the diagonal shift
   task automatic push_expected();
      logic [B-1:0] acc[NR];
      int s;
      int sp;
      for (int r = 0; r < NR; r++) acc[r] = '0;
      for (int c = 0; c < NI; c++) begin
         for (int r = 0; r < NR; r++) begin
            s = int'(shift_at(r, c));
            if (s != B) acc[r] = acc[r] ^ ref_rot(info_buf[c], s);
         end
         sb_q.push_back({1'b0, info_buf[c]});
      end
      for (int r = 0; r < NR; r++) begin
         sp = int'(shift_at(r, NI + r));
         sb_q.push_back({(r == NR - 1), ref_rot(acc[r], (B - sp) % B)});
      end
   endtask

   always begin
      @(negedge clk);
      i_codeword_ready = #1 (rdy_mode == 1) ? 1'($urandom_range(1)) : 1'b1;
   end

   // Monitor samples one time unit before each rising edge
   always begin
      logic [B:0] expv;
      @(negedge clk);
      #4;
      if (rst) begin
         hold_pend = 1'b0;
         beat = 0;
      end else begin
         if (hold_pend) begin
            checks++;
            if (o_codeword_valid !== 1'b1 || o_codeword !== hold_d || o_codeword_last !== hold_l)
            begin
               errors++;
               $display("FAIL hold: valid=%b last=%b data=%h, required valid=1 last=%b data=%h",
                        o_codeword_valid, o_codeword_last, o_codeword, hold_l, hold_d);
            end
         end
         hold_pend = (o_codeword_valid === 1'b1) && (i_codeword_ready === 1'b0);
         hold_d = o_codeword;
         hold_l = o_codeword_last;
         if (o_check_err === 1'b1) begin
            err_pulses++;
            err_cyc = cyc;
         end
         if (!err_allowed) begin
            checks++;
            if (o_check_err !== 1'b0) begin
               errors++;
               $display("FAIL check_err: got %b, required 0", o_check_err);
            end
         end
         if (o_codeword_valid === 1'b1 && i_codeword_ready === 1'b1) begin
            hand_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (beat < NC) frame_buf[beat] = o_codeword;
            beat++;
            if (sb_en) begin
               checks++;
               if (sb_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_output: got last=%b data=%h, required no output",
                           o_codeword_last, o_codeword);
               end else begin
                  expv = sb_q.pop_front();
                  if ({o_codeword_last, o_codeword} !== expv) begin
                     errors++;
                     $display("FAIL column %0d: got last=%b data=%h, required last=%b data=%h",
                              beat - 1, o_codeword_last, o_codeword, expv[B], expv[B-1:0]);
                  end
               end
            end
            if (o_codeword_last === 1'b1) begin
               if (sb_en) begin
                  checks++;
                  if (beat != NC || !syndrome_ok()) begin
                     errors++;
                     $display("FAIL syndrome: got beats=%0d ok=%b, required beats=72 ok=1",
                              beat, syndrome_ok());
                  end
               end
               beat = 0;
            end
         end
      end
   end

   // Drive info columns c0..c1-1 from info_buf with random valid gaps
   task automatic drive_frame(input int c0, input int c1, input int gap_pct);
      for (int c = c0; c < c1; c++) begin
         bit done = 1'b0;
         int budget = 0;
         while (!done) begin
            @(negedge clk);
            #1;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
               i_info_valid = 1'b0;
               i_info = rand127();
            end else begin
               i_info_valid = 1'b1;
               i_info = info_buf[c];
            end
            #3;
            if (i_info_valid && o_info_ready === 1'b1) begin
               done = 1'b1;
               if (c == 0) first_acc_cyc = cyc;
            end
            budget++;
            if (!done && budget > 500) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout: column %0d not accepted, required accept", c);
               return;
            end
         end
      end
   endtask

   task automatic wait_drain();
      int budget = 0;
      @(negedge clk);
      #1;
      i_info_valid = 1'b0;
      while (sb_q.size() != 0 && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending columns, required 0", sb_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #4;
      checks += 5;
      if (o_info_ready !== 1'b0) begin
         errors++; $display("FAIL rst_ready: got %b, required 0", o_info_ready);
      end
      if (o_codeword_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid: got %b, required 0", o_codeword_valid);
      end
      if (o_codeword_last !== 1'b0) begin
         errors++; $display("FAIL rst_last: got %b, required 0", o_codeword_last);
      end
      if (o_check_err !== 1'b0) begin
         errors++; $display("FAIL rst_check_err: got %b, required 0", o_check_err);
      end
      if (o_codeword !== '0) begin
         errors++; $display("FAIL rst_codeword: got %h, required 0", o_codeword);
      end
      @(negedge clk);
      #1 rst = 1'b0;
      #3;
      checks += 2;
      if (o_info_ready !== 1'b1) begin
         errors++; $display("FAIL ready_after_rst: got %b, required 1", o_info_ready);
      end
      if (o_codeword_valid !== 1'b0) begin
         errors++; $display("FAIL valid_after_rst: got %b, required 0", o_codeword_valid);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (hand_cnt != 0) begin
         errors++; $display("FAIL idle_output: got %0d columns, required 0", hand_cnt);
      end
   endtask

   task automatic test_zero_frame();
      rdy_mode = 0;
      for (int c = 0; c < NI; c++) info_buf[c] = '0;
      push_expected();
      first_cyc = -1;
      hand_cnt = 0;
      drive_frame(0, NI, 0);
      wait_drain();
      checks += 3;
      if (hand_cnt != NC) begin
         errors++; $display("FAIL zero_count: got %0d, required 72", hand_cnt);
      end
      if (last_cyc - first_cyc != NC - 1) begin
         errors++; $display("FAIL zero_span: got %0d cycles, required 71", last_cyc - first_cyc);
      end
      if (first_cyc - first_acc_cyc != 1) begin
         errors++;
         $display("FAIL latency: got %0d cycles, required 1", first_cyc - first_acc_cyc);
      end
   endtask

   task automatic test_single_bit();
      int s0;
      int sp;
      rdy_mode = 0;
      for (int c = 0; c < NI; c++) info_buf[c] = '0;
      info_buf[0][0] = 1'b1;
      for (int c = 0; c < NI; c++) sb_q.push_back({1'b0, info_buf[c]});
      // Parity r has a single one at (sp[r] - s[r][0]) mod 127, or is zero for a zero block
      for (int r = 0; r < NR; r++) begin
         logic [B-1:0] pc;
         s0 = int'(shift_at(r, 0));
         sp = int'(shift_at(r, NI + r));
         pc = '0;
         if (s0 != B) pc[(sp - s0 + B) % B] = 1'b1;
         sb_q.push_back({(r == NR - 1), pc});
      end
      drive_frame(0, NI, 0);
      wait_drain();
   endtask

   task automatic test_back_to_back();
      rdy_mode = 0;
      first_cyc = -1;
      hand_cnt = 0;
      for (int c = 0; c < NI; c++) info_buf[c] = rand127();
      push_expected();
      drive_frame(0, NI, 0);
      for (int c = 0; c < NI; c++) info_buf[c] = rand127();
      push_expected();
      drive_frame(0, NI, 0);
      wait_drain();
      checks += 2;
      if (hand_cnt != 2 * NC) begin
         errors++; $display("FAIL b2b_count: got %0d, required 144", hand_cnt);
      end
      if (last_cyc - first_cyc != 2 * NC - 1) begin
         errors++; $display("FAIL b2b_span: got %0d cycles, required 143", last_cyc - first_cyc);
      end
   endtask

   task automatic test_random();
      rdy_mode = 1;
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < NI; c++) info_buf[c] = rand127();
         push_expected();
         drive_frame(0, NI, 30);
      end
      wait_drain();
      rdy_mode = 0;
   endtask

   task automatic test_reset_mid_frame();
      rdy_mode = 0;
      for (int c = 0; c < NI; c++) info_buf[c] = rand127();
      push_expected();
      drive_frame(0, 30, 0);
      @(negedge clk);
      #1;
      i_info_valid = 1'b0;
      rst = 1'b1;
      #3;
      checks += 2;
      if (o_codeword_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_valid: got %b, required 0", o_codeword_valid);
      end
      if (o_info_ready !== 1'b0) begin
         errors++; $display("FAIL midrst_ready: got %b, required 0", o_info_ready);
      end
      @(negedge clk);
      sb_q.delete();
      #1 rst = 1'b0;
      for (int c = 0; c < NI; c++) info_buf[c] = rand127();
      push_expected();
      drive_frame(0, NI, 20);
      wait_drain();
   endtask

`ifdef ENC_SELF_CHECK_EN
   task automatic test_self_check();
      rdy_mode = 0;
      sb_en = 1'b0;
      err_allowed = 1'b1;
      err_pulses = 0;
      for (int c = 0; c < NI; c++) info_buf[c] = '0;
      drive_frame(0, 10, 0);
      @(negedge clk);
      #1;
      i_info_valid = 1'b0;
      force u_dut.acc_q[0][5] = 1'b1;
      @(negedge clk);
      #1;
      release u_dut.acc_q[0][5];
      drive_frame(10, NI, 0);
      @(negedge clk);
      #1 i_info_valid = 1'b0;
      repeat (20) @(negedge clk);
      checks += 2;
      if (err_pulses != 1) begin
         errors++; $display("FAIL selfcheck_pulses: got %0d, required 1", err_pulses);
      end
      if (err_cyc != last_cyc + 1) begin
         errors++;
         $display("FAIL selfcheck_timing: got cycle %0d, required %0d", err_cyc, last_cyc + 1);
      end
      err_allowed = 1'b0;
      sb_en = 1'b1;
      for (int c = 0; c < NI; c++) info_buf[c] = rand127();
      push_expected();
      drive_frame(0, NI, 0);
      wait_drain();
   endtask
`endif

   initial begin
      test_reset();
      test_zero_frame();
      test_single_bit();
      test_back_to_back();
      test_random();
      test_reset_mid_frame();
`ifdef ENC_SELF_CHECK_EN
      test_self_check();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

endmodule
